// File: rtl/kd_tree_ctrl.sv
// kd_tree_ctrl
//   Sequencer for the root command/data port of the kd_tree node array.
//   A run does the following in order:
//     1. reset the tree;
//     2. stream NUM_CENTERS centers into it;
//     3. start the sort;
//     4. feed points one at a time, returning each best-center result to
//        the host.
//
// Ports
//   clk, reset    clock; asynchronous active-low reset (0 = reset)
//   start         1-cycle pulse, honoured in IDLE and ERR only
//   ctr_*         center input stream {R,G,B}
//   pt_*          point input stream {R,G,B}; pt_last marks the final point
//   best_*        result output stream (data_to_top captured on return_best)
//   tree_cmd/data registered command_from_top / data_from_top of the root node
//   tree_cmd_up/data_up  command_to_top / data_to_top of the root node
//   busy          high in every state except IDLE
//   done          1-cycle pulse when a run completes
//   error         high while parked in ERR (timeout or protocol fault)
//   state_dbg     current FSM state
//                 (IDLE=0 TRST=1 FILL=2 FILL_WAIT=3 SORT=4 SORT_WAIT=5
//                  PT_IN=6 PT_Q=7 PT_OUT=8 DONE=9 ERR=10)
//
// Handshakes: a word moves on a rising edge where valid and ready are both
// high. ready/valid driven by this block are registered. best_valid stays
// high and best_data stays stable until the edge where best_ready is seen.
module kd_tree_ctrl #(
    parameter int NUM_CENTERS = 7,
    parameter int DIM_W       = 8,
    parameter int CENTER_W    = 3 * DIM_W,
    parameter int DATA_W      = 2 * CENTER_W,
    parameter int CMD_W       = 5,
    parameter int TIMEOUT     = 1023
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                ctr_valid,
    output logic                ctr_ready,
    input  logic [CENTER_W-1:0] ctr_data,
    input  logic                pt_valid,
    input  logic                pt_last,
    output logic                pt_ready,
    input  logic [CENTER_W-1:0] pt_data,
    output logic                best_valid,
    input  logic                best_ready,
    output logic [DATA_W-1:0]   best_data,
    output logic [CMD_W-1:0]    tree_cmd,
    output logic [DATA_W-1:0]   tree_data,
    input  logic [CMD_W-1:0]    tree_cmd_up,
    input  logic [DATA_W-1:0]   tree_data_up,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [3:0]          state_dbg
);

    localparam logic [CMD_W-1:0] CMD_NOP         = CMD_W'('h00);
    localparam logic [CMD_W-1:0] CMD_CENTER_FILL = CMD_W'('h01);
    localparam logic [CMD_W-1:0] CMD_FILL_DONE   = CMD_W'('h05);
    localparam logic [CMD_W-1:0] CMD_START_SORT  = CMD_W'('h14);
    localparam logic [CMD_W-1:0] CMD_SORT_DONE   = CMD_W'('h15);
    localparam logic [CMD_W-1:0] CMD_POINT_IN    = CMD_W'('h16);
    localparam logic [CMD_W-1:0] CMD_RETURN_BEST = CMD_W'('h18);
    localparam logic [CMD_W-1:0] CMD_RST_DONE    = CMD_W'('h1e);
    localparam logic [CMD_W-1:0] CMD_RST         = CMD_W'('h1f);

    localparam int              CNT_W    = $clog2(NUM_CENTERS + 1);
    localparam logic [CNT_W-1:0] NUM_C    = CNT_W'(NUM_CENTERS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_CENTERS - 1);
    localparam int              TMO_W    = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam int              PAD_W    = DATA_W - CENTER_W;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_TRST      = 4'd1,
        S_FILL      = 4'd2,
        S_FILL_WAIT = 4'd3,
        S_SORT      = 4'd4,
        S_SORT_WAIT = 4'd5,
        S_PT_IN     = 4'd6,
        S_PT_Q      = 4'd7,
        S_PT_OUT    = 4'd8,
        S_DONE      = 4'd9,
        S_ERR       = 4'd10
    } state_t;

    state_t             state_q, next_state;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic               last_q, last_d;

    logic [CMD_W-1:0]   tree_cmd_d;
    logic [DATA_W-1:0]  tree_data_d;
    logic [DATA_W-1:0]  best_data_d;
    logic               ctr_ready_d, pt_ready_d, best_valid_d;
    logic               busy_d, done_d, error_d;

    logic               ctr_fire, pt_fire, best_fire;
    logic               is_wait, tmo_hit;

    assign ctr_fire  = ctr_valid & ctr_ready;
    assign pt_fire   = pt_valid & pt_ready;
    assign best_fire = best_valid & best_ready;
    assign state_dbg = state_q;

    // Only states that wait on the tree are guarded by the timeout; FILL,
    // PT_IN and PT_OUT wait on the host, which may stall indefinitely.
    assign is_wait = (state_q == S_TRST) || (state_q == S_FILL_WAIT) ||
                     (state_q == S_SORT_WAIT) || (state_q == S_PT_Q);
    // tmo_q counts cycles already spent in the state, so this fires on the
    // TIMEOUT-th cycle without a response.
    assign tmo_hit = is_wait && (tmo_q == TMO_LAST);

    // State register plus every registered output.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            tmo_q      <= '0;
            last_q     <= 1'b0;
            tree_cmd   <= CMD_NOP;
            tree_data  <= '0;
            ctr_ready  <= 1'b0;
            pt_ready   <= 1'b0;
            best_valid <= 1'b0;
            best_data  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            state_q    <= next_state;
            cnt_q      <= cnt_d;
            tmo_q      <= tmo_d;
            last_q     <= last_d;
            tree_cmd   <= tree_cmd_d;
            tree_data  <= tree_data_d;
            ctr_ready  <= ctr_ready_d;
            pt_ready   <= pt_ready_d;
            best_valid <= best_valid_d;
            best_data  <= best_data_d;
            busy       <= busy_d;
            done       <= done_d;
            error      <= error_d;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state_q;
        case (state_q)
            S_IDLE:      if (start) next_state = S_TRST;
            S_TRST:      if (tree_cmd_up == CMD_RST_DONE) next_state = S_FILL;
                         else if (tmo_hit) next_state = S_ERR;
            // A fill_done before all centers are sent means the tree and this
            // block disagree on the center count.
            S_FILL:      if (tree_cmd_up == CMD_FILL_DONE) next_state = S_ERR;
                         else if (ctr_fire && cnt_q == CNT_LAST) next_state = S_FILL_WAIT;
            S_FILL_WAIT: if (tree_cmd_up == CMD_FILL_DONE) next_state = S_SORT;
                         else if (tmo_hit) next_state = S_ERR;
            S_SORT:      next_state = S_SORT_WAIT;
            S_SORT_WAIT: if (tree_cmd_up == CMD_SORT_DONE) next_state = S_PT_IN;
                         else if (tmo_hit) next_state = S_ERR;
            S_PT_IN:     if (pt_fire) next_state = S_PT_Q;
            S_PT_Q:      if (tree_cmd_up == CMD_RETURN_BEST) next_state = S_PT_OUT;
                         else if (tmo_hit) next_state = S_ERR;
            S_PT_OUT:    if (best_fire) next_state = last_q ? S_DONE : S_PT_IN;
            S_DONE:      next_state = S_IDLE;
            S_ERR:       if (start) next_state = S_TRST;
            default:     next_state = S_IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs, derived from the
    // transition being taken so that each output lines up with its state.
    always_comb begin
        tree_cmd_d   = CMD_NOP;
        tree_data_d  = tree_data;
        best_valid_d = best_valid;
        best_data_d  = best_data;
        cnt_d        = cnt_q;
        last_d       = last_q;
        pt_ready_d   = (next_state == S_PT_IN);
        busy_d       = (next_state != S_IDLE);
        done_d       = (next_state == S_DONE);
        error_d      = (next_state == S_ERR);
        tmo_d        = '0;

        if (is_wait && next_state == state_q) tmo_d = tmo_q + TMO_W'(1);

        case (next_state)
            S_TRST: tree_cmd_d = CMD_RST;
            S_SORT: begin
                tree_cmd_d  = CMD_START_SORT;
                tree_data_d = '0;
            end
            S_PT_Q: tree_cmd_d = CMD_POINT_IN;
            default: ;
        endcase

        if ((state_q == S_IDLE || state_q == S_ERR) && next_state == S_TRST)
            cnt_d = '0;

        // The command goes out only on the cycle following a handshake;
        // cycles without one are nop.
        if (state_q == S_FILL && ctr_fire && next_state != S_ERR) begin
            tree_cmd_d  = CMD_CENTER_FILL;
            tree_data_d = {{PAD_W{1'b0}}, ctr_data};
            cnt_d       = cnt_q + CNT_W'(1);
        end

        ctr_ready_d = (next_state == S_FILL) && (cnt_d < NUM_C);

        // tree_data holds the point for the whole PT_Q query.
        if (pt_fire) begin
            tree_data_d = {{PAD_W{1'b0}}, pt_data};
            last_d      = pt_last;
        end

        if (state_q == S_PT_Q && next_state == S_PT_OUT) begin
            best_valid_d = 1'b1;
            best_data_d  = tree_data_up;
        end

        if (best_fire) best_valid_d = 1'b0;
    end

endmodule

// File: tb/tb_kd_tree_ctrl.sv
// Testbench for kd_tree_ctrl: directed runs with a small hand-driven tree
// responder. Expected tree commands and best results go into queues and a
// negedge monitor pops and compares them as the DUT produces them.
module tb_kd_tree_ctrl;

    localparam int TIMEOUT = 1023;

    localparam logic [4:0] C_NOP   = 5'h00;
    localparam logic [4:0] C_FILL  = 5'h01;
    localparam logic [4:0] C_FDONE = 5'h05;
    localparam logic [4:0] C_SORT  = 5'h14;
    localparam logic [4:0] C_SDONE = 5'h15;
    localparam logic [4:0] C_PTIN  = 5'h16;
    localparam logic [4:0] C_RBEST = 5'h18;
    localparam logic [4:0] C_RDONE = 5'h1e;
    localparam logic [4:0] C_RST   = 5'h1f;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    always #5 clk = ~clk;

    logic        start = 1'b0;
    logic        ctr_valid = 1'b0;
    logic        ctr_ready;
    logic [23:0] ctr_data = '0;
    logic        pt_valid = 1'b0;
    logic        pt_last = 1'b0;
    logic        pt_ready;
    logic [23:0] pt_data = '0;
    logic        best_valid;
    logic        best_ready = 1'b0;
    logic [47:0] best_data;
    logic [4:0]  tree_cmd;
    logic [47:0] tree_data;
    logic [4:0]  tree_cmd_up = C_NOP;
    logic [47:0] tree_data_up = '0;
    logic        busy, done, error;
    logic [3:0]  state_dbg;

    kd_tree_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .start(start),
        .ctr_valid(ctr_valid), .ctr_ready(ctr_ready), .ctr_data(ctr_data),
        .pt_valid(pt_valid), .pt_last(pt_last), .pt_ready(pt_ready), .pt_data(pt_data),
        .best_valid(best_valid), .best_ready(best_ready), .best_data(best_data),
        .tree_cmd(tree_cmd), .tree_data(tree_data),
        .tree_cmd_up(tree_cmd_up), .tree_data_up(tree_data_up),
        .busy(busy), .done(done), .error(error), .state_dbg(state_dbg)
    );

    // ---------------- scoreboard ----------------
    int          n_vec = 0;
    int          n_fail = 0;
    int          done_cnt = 0;
    logic [52:0] exp_tree_q[$];
    logic [47:0] exp_best_q[$];
    logic [4:0]  prev_cmd = C_NOP;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every center_fill / start_sort cycle and every new point_in
    // is one expected tree event; every best handshake is one expected result.
    always @(negedge clk) begin
        logic [52:0] e_tree;
        logic [47:0] e_best;
        if (reset && (tree_cmd == C_FILL || tree_cmd == C_SORT ||
                      (tree_cmd == C_PTIN && prev_cmd != C_PTIN))) begin
            if (exp_tree_q.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL tree_event: got %h/%h expected nothing", tree_cmd, tree_data);
            end else begin
                e_tree = exp_tree_q.pop_front();
                check("tree_event", {11'b0, tree_cmd, tree_data}, {11'b0, e_tree});
            end
        end
        prev_cmd = tree_cmd;
        if (best_valid && best_ready) begin
            if (exp_best_q.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL best_result: got %h expected nothing", best_data);
            end else begin
                e_best = exp_best_q.pop_front();
                check("best_result", {16'b0, best_data}, {16'b0, e_best});
            end
        end
        if (done) done_cnt++;
    end

    initial begin
        #(2_000_000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Answer rst_done during the n-th rst cycle; count rst cycles seen.
    task automatic tree_reset(input int n);
        int seen;
        seen = 0;
        for (int i = 0; i < n; i++) begin
            if (tree_cmd == C_RST) seen++;
            if (i == n - 1) tree_cmd_up = C_RDONE;
            tick();
        end
        tree_cmd_up = C_NOP;
        check("rst_cycles", 64'(seen), 64'(n));
        check("fill_ctr_ready", {63'b0, ctr_ready}, 64'd1);
        check("fill_tree_nop", {59'b0, tree_cmd}, {59'b0, C_NOP});
    endtask

    task automatic send_center(input logic [23:0] c);
        logic fired;
        fired = 1'b0;
        ctr_valid = 1'b1;
        ctr_data = c;
        for (int i = 0; i < 20 && !fired; i++) begin
            fired = ctr_ready;
            tick();
        end
        ctr_valid = 1'b0;
        if (!fired) begin
            n_vec++;
            n_fail++;
            $display("FAIL ctr_handshake: ready 0 for center %h expected 1", c);
        end
    endtask

    task automatic fill_centers(input logic [23:0] base, input logic gaps);
        logic [23:0] c;
        for (int i = 0; i < 7; i++) begin
            c = base + 24'(i);
            exp_tree_q.push_back({C_FILL, 24'h0, c});
            send_center(c);
            if (gaps) for (int g = 0; g < i % 3; g++) tick();
        end
        check("ctr_ready_after_fill", {63'b0, ctr_ready}, 64'd0);
        tick();
        check("fill_wait_nop", {59'b0, tree_cmd}, {59'b0, C_NOP});
    endtask

    // From FILL_WAIT: answer center_fill_done, leave the DUT in SORT_WAIT.
    task automatic sort_start();
        exp_tree_q.push_back({C_SORT, 48'h0});
        tree_cmd_up = C_FDONE;
        tick();
        tree_cmd_up = C_NOP;
        tick();
        check("sort_wait_nop", {59'b0, tree_cmd}, {59'b0, C_NOP});
    endtask

    task automatic sort_finish(input int delay);
        for (int i = 0; i < delay; i++) begin
            tick();
            check("sort_wait_nop", {59'b0, tree_cmd}, {59'b0, C_NOP});
        end
        tree_cmd_up = C_SDONE;
        tick();
        tree_cmd_up = C_NOP;
        check("pt_ready_after_sort", {63'b0, pt_ready}, 64'd1);
    endtask

    task automatic send_point(input logic [23:0] p, input logic last);
        logic fired;
        fired = 1'b0;
        pt_valid = 1'b1;
        pt_data = p;
        pt_last = last;
        for (int i = 0; i < 20 && !fired; i++) begin
            fired = pt_ready;
            tick();
        end
        pt_valid = 1'b0;
        pt_last = 1'b0;
        if (!fired) begin
            n_vec++;
            n_fail++;
            $display("FAIL pt_handshake: ready 0 for point %h expected 1", p);
        end
    endtask

    // One query: tree answers return_best after 'delay' point_in cycles,
    // host holds best_ready low for 'hold' cycles.
    task automatic do_point(input logic [23:0] p, input logic last, input int delay,
                            input logic [47:0] resp, input int hold);
        logic fired;
        exp_tree_q.push_back({C_PTIN, 24'h0, p});
        exp_best_q.push_back(resp);
        send_point(p, last);
        for (int i = 0; i < delay; i++) begin
            check("point_in_held", {11'b0, tree_cmd, tree_data}, {11'b0, C_PTIN, 24'h0, p});
            tick();
        end
        tree_cmd_up = C_RBEST;
        tree_data_up = resp;
        tick();
        tree_cmd_up = C_NOP;
        tree_data_up = 48'hDEAD_BEEF_0123;
        for (int i = 0; i < hold; i++) begin
            check("best_valid_held", {63'b0, best_valid}, 64'd1);
            check("best_data_stable", {16'b0, best_data}, {16'b0, resp});
            check("pt_ready_while_out", {63'b0, pt_ready}, 64'd0);
            check("out_tree_nop", {59'b0, tree_cmd}, {59'b0, C_NOP});
            tick();
        end
        best_ready = 1'b1;
        fired = 1'b0;
        for (int i = 0; i < 20 && !fired; i++) begin
            fired = best_valid;
            tick();
        end
        best_ready = 1'b0;
        if (!fired) begin
            n_vec++;
            n_fail++;
            $display("FAIL best_handshake: best_valid 0 for point %h expected 1", p);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_tree_cmd"}, {59'b0, tree_cmd}, {59'b0, C_NOP});
        check({tag, "_tree_data"}, {16'b0, tree_data}, 64'd0);
        check({tag, "_best_data"}, {16'b0, best_data}, 64'd0);
        check({tag, "_flags"},
              {56'b0, ctr_ready, pt_ready, best_valid, busy, done, error, 2'b0}, 64'd0);
        check({tag, "_state"}, {60'b0, state_dbg}, 64'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        tick();
        tick();
        check_reset_values("reset");
        reset = 1'b1;
        tick();

        // T1: tree reset answered on the 3rd rst cycle
        start_run();
        check("busy_run", {63'b0, busy}, 64'd1);
        tree_reset(3);

        // T2: 7 centers with valid gaps, then sort
        fill_centers(24'h0A0000, 1'b1);
        sort_start();
        sort_finish(3);

        // T3: single point, tree answers after 5 cycles, host stalls 4 cycles
        do_point(24'h0A000A, 1'b0, 5, 48'h000000_0A0005, 4);

        // T4: three more points, last flagged
        do_point(24'h0A0010, 1'b0, 1, 48'h000001_0A0003, 0);
        do_point(24'h0A0020, 1'b0, 2, 48'h000002_0A0006, 1);
        do_point(24'h0A0030, 1'b1, 3, 48'h000003_0A0002, 0);
        check("done_pulse", {62'b0, done, busy}, 64'd3);
        tick();
        check("after_done", {62'b0, done, busy}, 64'd0);
        check("idle_state", {60'b0, state_dbg}, 64'd0);

        // T5: sort_done never arrives
        start_run();
        tree_reset(1);
        fill_centers(24'h0B0000, 1'b0);
        sort_start();
        n = 0;
        while (!error && n < TIMEOUT + 20) begin
            tick();
            n++;
        end
        check("timeout_cycles", 64'(n), 64'(TIMEOUT));
        check("err_outputs", {57'b0, tree_cmd, busy, ctr_ready}, {57'b0, C_NOP, 1'b1, 1'b0});
        start_run();
        check("restart_error_clear", {63'b0, error}, 64'd0);
        check("restart_tree_rst", {59'b0, tree_cmd}, {59'b0, C_RST});

        // T6: reset asserted while a query is outstanding
        tree_reset(2);
        fill_centers(24'h0C0000, 1'b1);
        sort_start();
        sort_finish(1);
        exp_tree_q.push_back({C_PTIN, 24'h0, 24'h0C0055});
        send_point(24'h0C0055, 1'b0);
        tick();
        check("pt_q_before_reset", {59'b0, tree_cmd}, {59'b0, C_PTIN});
        reset = 1'b0;
        tick();
        check_reset_values("midrun_reset");
        reset = 1'b1;
        tick();
        check("no_tree_rerst", {59'b0, tree_cmd}, {59'b0, C_NOP});
        start_run();
        tree_reset(3);
        fill_centers(24'h0D0000, 1'b0);
        sort_start();
        sort_finish(0);
        do_point(24'h0D0077, 1'b1, 2, 48'h000004_0D0001, 2);
        check("done_pulse2", {62'b0, done, busy}, 64'd3);
        tick();
        check("after_done2", {62'b0, done, busy}, 64'd0);

        tick();
        tick();
        check("tree_q_empty", 64'(exp_tree_q.size()), 64'd0);
        check("best_q_empty", 64'(exp_best_q.size()), 64'd0);
        check("done_count", 64'(done_cnt), 64'd2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
